sort_stream: RTL
================

# sort_stream

Streaming counterpart to the combinational eight-input `sort` network. It accepts a frame of up to N unsigned bytes one per cycle over a valid/ready input stream and insertion-sorts them into a register array as they arrive. It then emits the frame in descending order, largest first, one per cycle over a valid/ready output stream, with a last marker. It sits between a byte producer and any consumer that needs sorted frames without the area of a full parallel network.

## Interface
- `W`, 8: data width; comparison is unsigned.
- `N`, 8: maximum frame length (slots); N ≥ 2.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_data` in W: input byte.
- `in_valid` in 1: input byte present.
- `in_last` in 1: marks final byte of a short frame; qualified by `in_valid && in_ready`.
- `in_ready` out 1: block can accept a byte.
- `out_data` out W: current sorted byte.
- `out_valid` out 1: `out_data` valid.
- `out_last` out 1: `out_data` is the smallest byte of the frame.
- `out_ready` in 1: consumer accepts the byte.

## Operation
- Two-state FSM, FILL and DRAIN; reset state is FILL.
- FILL: `in_ready`=1, `out_valid`=0. On each input handshake the byte is inserted into slot array `s[0..N-1]`, kept descending, with `s[0]` the maximum. The occupancy count `cnt` increments.
- Insertion rule per slot i (occupied flag `v[i]`):
  - Let `gt(i) = !v[i] || in_data > s[i]`.
  - Slot i loads `in_data` if `gt(i)` and (i==0 or !`gt(i-1)`).
  - Slot i loads `s[i-1]` if `gt(i-1)`.
  - Otherwise it holds.
  - Empty slots compare as smaller than any value.
  - Ties: the new byte goes after existing equal bytes.
- FILL → DRAIN on the handshake that makes `cnt`==N or carries `in_last`=1. A byte with `in_last` is inserted normally.
- DRAIN: `in_ready`=0, `out_valid`=1, `out_data`=`s[0]`, `out_last`=(`cnt`==1).
  - On `out_ready`, the array shifts up one: `s[i]`←`s[i+1]`, `v[N-1]`←0, and `cnt` decrements.
  - A handshake with `out_last`=1 returns the FSM to FILL with the array empty.
- `out_data`, `out_valid` and `out_last` hold stable while `out_valid && !out_ready`.
- Inputs are ignored in DRAIN. Input and output handshakes never coincide.
- Frame lengths 1..N are supported. A frame of length 1 drains in one output beat with `out_last`=1.

## Timing
- Reset values:
  - `in_ready`=1, `out_valid`=0, `out_data`=0, `out_last`=0.
  - All `s`=0, all `v`=0, `cnt`=0, state FILL.
- Reset may assert at any time, including mid-fill or mid-drain. The partial frame is discarded; no output beat follows.
- Latency: `out_valid` rises the cycle after the final input handshake.
- Throughput: one byte per cycle in each phase, with no back-pressure stalls. A full frame of N bytes takes N fill cycles plus N drain cycles.
- First input is accepted in the first cycle after `rst_n` deasserts. After the last output handshake, `in_ready`=1 in the next cycle.
- All outputs are driven from registers or from the state register only; there is no combinational path from `in_*` to `out_*`.

## Structure
- Package `sort_pkg`: default `W`/`N` localparams and the state enum (`FILL`, `DRAIN`).
- Sub-module `sort_slot`: one slot register with its occupancy flag, `gt` compare and insert/shift/hold mux. Generated N times in `sort_stream` and chained through `gt` and the neighbour data.
- Top level holds the FSM, `cnt` (width $clog2(N+1)) and the handshake logic.

## Test plan
- Full frame: 8 bytes 3,200,7,7,0,255,42,1 with `out_ready`=1. Output must be 255,200,42,7,7,3,1,0, with `out_last` only on the 0. `in_ready`=0 for exactly 8 cycles.
- Short frame: 5,9,2 with `in_last` on the 2. Output must be 9,5,2, `out_last` on the 2, then `in_ready`=1 the next cycle.
- Back-pressure: random `out_ready` toggling on a full frame. `out_data` and `out_last` must stay stable while stalled, the sequence must be unchanged, and no beat may be dropped or duplicated.
- Boundaries:
  - All-equal frame of 8×0x80: 8 beats of 0x80.
  - Single byte 0x00 with `in_last`: one beat, `out_last`=1.
  - Both 0 and 255 must sort correctly as unsigned values.
- Reset mid-operation: assert `rst_n`=0 after 4 inputs, and separately after 3 outputs. All outputs must return to reset values, and a following frame 1,2 must output 2,1.
- Ignored input: hold `in_valid`=1 with changing data during DRAIN. Drained data must be unaffected, and those bytes must not appear in the next frame.

Source files
------------

// File: rtl/sort_pkg.sv
// Shared defaults and FSM state type for the streaming insertion sorter.
package sort_pkg;
  localparam int W_DEF = 8;
  localparam int N_DEF = 8;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;
endpackage

// File: rtl/sort_stream_if.sv
// Valid/ready byte stream with an end-of-frame marker.
interface sort_stream_if
  import sort_pkg::*;
#(
  parameter int W = W_DEF
);
  logic [W-1:0] data;
  logic         valid;
  logic         last;
  logic         ready;

  modport master(output data, output valid, output last, input ready);
  modport slave(input data, input valid, input last, output ready);
endinterface

// File: rtl/sort_slot.sv
// One sorter slot: value register, occupancy flag, compare against the
// incoming byte, and the insert/shift/hold selection.
module sort_slot
  import sort_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         insert,
  input  logic         shift,
  input  logic [W-1:0] din,
  input  logic         prev_gt,
  input  logic [W-1:0] prev_data,
  input  logic         prev_v,
  input  logic [W-1:0] next_data,
  input  logic         next_v,
  output logic [W-1:0] data,
  output logic         valid,
  output logic         gt
);
  logic [W-1:0] s_reg, s_next;
  logic         v_reg, v_next;

  // Strict compare keeps a new byte behind existing equal bytes.
  assign gt    = !v_reg || (din > s_reg);
  assign data  = s_reg;
  assign valid = v_reg;

  always_comb begin
    s_next = s_reg;
    v_next = v_reg;
    if (insert) begin
      if (prev_gt) begin
        s_next = prev_data;
        v_next = prev_v;
      end else if (gt) begin
        s_next = din;
        v_next = 1'b1;
      end
    end else if (shift) begin
      s_next = next_data;
      v_next = next_v;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_reg <= '0;
      v_reg <= 1'b0;
    end else begin
      s_reg <= s_next;
      v_reg <= v_next;
    end
  end
endmodule

// File: rtl/sort_stream.sv
// Streaming sorter: insertion-sorts up to N bytes as they arrive, then
// emits them largest first with a last marker on the smallest.
module sort_stream
  import sort_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int N = N_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  sort_stream_if.slave  in_s,
  sort_stream_if.master out_s
);
  localparam int CW = $clog2(N + 1);

  state_t         state_reg, state_next;
  logic [CW-1:0]  cnt_reg, cnt_next;
  logic [W-1:0]   s_arr  [N];
  logic           v_arr  [N];
  logic           gt_arr [N];
  logic           fill_hs;
  logic           drain_hs;

  assign fill_hs  = (state_reg == FILL) && in_s.valid;
  assign drain_hs = (state_reg == DRAIN) && out_s.ready;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_slot
      logic [W-1:0] prev_data;
      logic [W-1:0] next_data;
      logic         prev_gt;
      logic         prev_v;
      logic         next_v;

      if (gi == 0) begin : g_head
        assign prev_gt   = 1'b0;
        assign prev_data = '0;
        assign prev_v    = 1'b0;
      end else begin : g_body
        assign prev_gt   = gt_arr[gi-1];
        assign prev_data = s_arr[gi-1];
        assign prev_v    = v_arr[gi-1];
      end

      // The tail refills with an empty slot as the array drains upward.
      if (gi == N - 1) begin : g_tail
        assign next_data = '0;
        assign next_v    = 1'b0;
      end else begin : g_mid
        assign next_data = s_arr[gi+1];
        assign next_v    = v_arr[gi+1];
      end

      sort_slot #(.W(W)) u_slot (
        .clk      (clk),
        .rst_n    (rst_n),
        .insert   (fill_hs),
        .shift    (drain_hs),
        .din      (in_s.data),
        .prev_gt  (prev_gt),
        .prev_data(prev_data),
        .prev_v   (prev_v),
        .next_data(next_data),
        .next_v   (next_v),
        .data     (s_arr[gi]),
        .valid    (v_arr[gi]),
        .gt       (gt_arr[gi])
      );
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      FILL: begin
        if (fill_hs) begin
          cnt_next = cnt_reg + CW'(1);
          if (in_s.last || (cnt_reg == CW'(N - 1))) state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_hs) begin
          cnt_next = cnt_reg - CW'(1);
          if (cnt_reg == CW'(1)) state_next = FILL;
        end
      end
      default: state_next = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= FILL;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Every output comes straight from the state, count or slot registers.
  assign in_s.ready  = (state_reg == FILL);
  assign out_s.valid = (state_reg == DRAIN);
  assign out_s.last  = (state_reg == DRAIN) && (cnt_reg == CW'(1));
  assign out_s.data  = s_arr[0];
endmodule
